qpu_exu_tiq_sched: RTL and testbench

- Timeline scheduler that sequences the execution-unit time queue.
- Keeps a relative cycle timer and compares it against the head entry of the time queue (wait interval since the previous trigger).
- When the head is due, issues a one-cycle trigger that pops the time queue and releases the matching event-queue slice.
- Stalls the timeline ("clock stop") while the queue is empty or while fast-feedback measurement results are outstanding.

---
 rtl/qpu_exu_tiq_sched.sv | 130 +++++++++++++
 tb/tb_qpu_exu_tiq_sched.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_tiq_sched.sv
// Timeline scheduler for the execution-unit time queue.
// A relative timer counts cycles since the last trigger. When the head entry
// of the time queue is due, a one-cycle trigger pops the queue and releases the
// matching event slice. The timeline freezes while the queue is empty or while
// a feedback measurement needed by the due event is still outstanding.
module qpu_exu_tiq_sched #(
    parameter int TIME_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_start,
    input  logic                  ctrl_stop,
    input  logic                  tiq_head_vld,
    input  logic [TIME_WIDTH-1:0] tiq_head_time,
    output logic                  tiq_pop,
    input  logic                  measure_pending,
    output logic                  trig_o,
    output logic [TIME_WIDTH-1:0] timer_o,
    output logic [1:0]            state_o,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  trig_cnt_o,
    output logic                  err_late_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_Q  = 2'd2,
        WAIT_FB = 2'd3
    } state_t;

    state_t                state;
    logic [TIME_WIDTH-1:0] timer;
    logic [CNT_WIDTH-1:0]  trig_cnt;
    logic                  err_late;
    logic                  due;
    logic                  fire;
    logic                  late;

    // Head is due once the elapsed interval reaches its programmed wait.
    assign due  = tiq_head_vld && (timer >= tiq_head_time);
    // A zero-wait head never counts as late; it simply fires on the first
    // evaluated cycle.
    assign late = (timer > tiq_head_time) && (tiq_head_time != '0);

    // Fire decision is same-cycle; stop and reset both suppress it.
    always_comb begin
        fire = 1'b0;
        if (!rst && !ctrl_stop && !measure_pending) begin
            case (state)
                RUN:     fire = due;
                WAIT_FB: fire = 1'b1;
                default: fire = 1'b0;
            endcase
        end
    end

    // Timeline FSM, relative timer, trigger counter and sticky late flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            trig_cnt <= '0;
            err_late <= 1'b0;
        end else begin
            if (fire) begin
                trig_cnt <= trig_cnt + CNT_WIDTH'(1);
                if (late)
                    err_late <= 1'b1;
            end
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (ctrl_start && !ctrl_stop) begin
                        state    <= RUN;
                        timer    <= TIME_WIDTH'(1);
                        trig_cnt <= '0;
                        err_late <= 1'b0;
                    end
                end
                RUN: begin
                    if (ctrl_stop) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (!tiq_head_vld) begin
                        state <= WAIT_Q;
                    end else if (due && measure_pending) begin
                        state <= WAIT_FB;
                    end else if (fire) begin
                        timer <= TIME_WIDTH'(1);
                    end else if (timer != '1) begin
                        timer <= timer + TIME_WIDTH'(1);
                    end
                end
                WAIT_Q: begin
                    // Re-enter RUN first; the compare happens there next cycle.
                    if (ctrl_stop) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (tiq_head_vld) begin
                        state <= RUN;
                    end
                end
                WAIT_FB: begin
                    if (ctrl_stop) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (!measure_pending) begin
                        state <= RUN;
                        timer <= TIME_WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign tiq_pop    = fire;
    assign trig_o     = fire;
    assign timer_o    = timer;
    assign state_o    = state;
    assign busy_o     = (state != IDLE);
    assign trig_cnt_o = trig_cnt;
    assign err_late_o = err_late;

endmodule

// File: tb/tb_qpu_exu_tiq_sched.sv
// Directed bench for the time-queue scheduler. A 4-bit timer keeps the
// all-ones head case short. The time queue is a bench-side list whose head is
// presented each cycle and which drops its head after a sampled pop.
module tb_qpu_exu_tiq_sched;

    localparam int TW = 4;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          ctrl_start;
    logic          ctrl_stop;
    logic          tiq_head_vld;
    logic [TW-1:0] tiq_head_time;
    logic          tiq_pop;
    logic          measure_pending;
    logic          trig_o;
    logic [TW-1:0] timer_o;
    logic [1:0]    state_o;
    logic          busy_o;
    logic [CW-1:0] trig_cnt_o;
    logic          err_late_o;

    int checks = 0;
    int errors = 0;
    int q[$];
    bit popped = 1'b0;
    bit mp     = 1'b0;
    bit rst_v  = 1'b1;

    qpu_exu_tiq_sched #(.TIME_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_start      (ctrl_start),
        .ctrl_stop       (ctrl_stop),
        .tiq_head_vld    (tiq_head_vld),
        .tiq_head_time   (tiq_head_time),
        .tiq_pop         (tiq_pop),
        .measure_pending (measure_pending),
        .trig_o          (trig_o),
        .timer_o         (timer_o),
        .state_o         (state_o),
        .busy_o          (busy_o),
        .trig_cnt_o      (trig_cnt_o),
        .err_late_o      (err_late_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: retire a popped head, drive this cycle's inputs,
    // then sample the pop decision.
    task automatic tick(input bit st = 1'b0, input bit sp = 1'b0);
        @(posedge clk);
        #1;
        if (popped && q.size() > 0)
            q.delete(0);
        rst             = rst_v;
        ctrl_start      = st;
        ctrl_stop       = sp;
        measure_pending = mp;
        tiq_head_vld    = (q.size() != 0);
        tiq_head_time   = (q.size() != 0) ? TW'(q[0]) : '0;
        #1;
        popped = tiq_pop;
    endtask

    initial begin
        rst             = 1'b1;
        ctrl_start      = 1'b0;
        ctrl_stop       = 1'b0;
        tiq_head_vld    = 1'b0;
        tiq_head_time   = '0;
        measure_pending = 1'b0;

        // Reset state
        tick(); tick();
        rst_v = 1'b0;
        tick();
        chk("rst_state", state_o, 0);
        chk("rst_timer", timer_o, 0);
        chk("rst_cnt", trig_cnt_o, 0);
        chk("rst_late", err_late_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_trig", trig_o, 0);

        // Basic spacing {3,5,1}: fires at cycles 3, 8, 9 after start
        q = {3, 5, 1};
        tick(1'b1, 1'b0);
        chk("t1_idle_at_start", state_o, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("t1_trig", trig_o, (k == 3 || k == 8 || k == 9));
        end
        chk("t1_cnt", trig_cnt_o, 3);
        chk("t1_late", err_late_o, 0);
        tick();
        chk("t1_waitq", state_o, 2);
        tick(1'b0, 1'b1);
        tick();
        chk("t1_stop_state", state_o, 0);
        chk("t1_stop_busy", busy_o, 0);

        // Empty stall: {2}, then empty, then {4}
        q = {2};
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t2_trig_a", trig_o, (k == 2));
            if (k >= 4) begin
                chk("t2_waitq_state", state_o, 2);
                chk("t2_waitq_timer", timer_o, 1);
            end
        end
        q.push_back(4);
        for (int k = 9; k <= 14; k++) begin
            tick();
            chk("t2_trig_b", trig_o, (k == 13));
            if (k == 10)
                chk("t2_restart_timer", timer_o, 1);
        end
        chk("t2_cnt", trig_cnt_o, 2);
        chk("t2_late", err_late_o, 0);
        tick(1'b0, 1'b1);
        tick();

        // Late entry: timer frozen at 5, then head {2} arrives
        q = {8};
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 4; k++)
            tick();
        chk("t3_timer4", timer_o, 4);
        q.delete();
        tick();
        chk("t3_timer5", timer_o, 5);
        for (int k = 6; k <= 15; k++) begin
            tick();
            chk("t3_frozen_state", state_o, 2);
            chk("t3_frozen_timer", timer_o, 5);
        end
        q.push_back(2);
        tick();
        chk("t3_no_fire_in_waitq", trig_o, 0);
        tick();
        chk("t3_late_fire", trig_o, 1);
        chk("t3_late_pop", tiq_pop, 1);
        tick();
        chk("t3_late_flag", err_late_o, 1);
        chk("t3_cnt", trig_cnt_o, 1);
        chk("t3_timer_after", timer_o, 1);
        tick(1'b0, 1'b1);
        tick();
        chk("t3_late_sticky", err_late_o, 1);
        chk("t3_idle", state_o, 0);

        // Feedback stall: head {3}, measure pending in cycles 3..7
        q = {3};
        mp = 1'b0;
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            mp = (k >= 3 && k <= 7);
            tick();
            chk("t4_trig", trig_o, (k == 8));
            chk("t4_pop", tiq_pop, (k == 8));
            if (k == 1)
                chk("t4_late_cleared", err_late_o, 0);
            if (k >= 4 && k <= 8)
                chk("t4_waitfb", state_o, 3);
        end
        chk("t4_timer", timer_o, 1);
        chk("t4_run", state_o, 1);
        mp = 1'b0;
        tick(1'b0, 1'b1);
        tick();

        // Start+stop together in IDLE, start ignored in RUN, stop beats fire
        tick(1'b1, 1'b1);
        tick();
        chk("t5_startstop_idle", state_o, 0);
        q = {2};
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        chk("t5_start_ignored_timer", timer_o, 2);
        chk("t5_stop_no_trig", trig_o, 0);
        chk("t5_stop_no_pop", tiq_pop, 0);
        tick();
        chk("t5_state", state_o, 0);
        chk("t5_timer", timer_o, 0);
        chk("t5_cnt", trig_cnt_o, 0);
        q.delete();

        // Reset mid-run with trig_cnt = 7, then zero-wait entry
        q = {1, 1, 1, 1, 1, 1, 1, 1};
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("t6_trig", trig_o, 1);
        end
        rst_v = 1'b1;
        tick();
        chk("t6_cnt7", trig_cnt_o, 7);
        chk("t6_rst_no_trig", trig_o, 0);
        chk("t6_rst_no_pop", tiq_pop, 0);
        rst_v = 1'b0;
        tick();
        chk("t6_state", state_o, 0);
        chk("t6_timer", timer_o, 0);
        chk("t6_cnt", trig_cnt_o, 0);
        chk("t6_late", err_late_o, 0);
        chk("t6_busy", busy_o, 0);
        chk("t6_trig_idle", trig_o, 0);
        q.delete();
        q.push_back(0);
        tick(1'b1, 1'b0);
        tick();
        chk("t6_zero_fire", trig_o, 1);
        tick();
        chk("t6_zero_cnt", trig_cnt_o, 1);
        chk("t6_zero_late", err_late_o, 0);
        tick(1'b0, 1'b1);
        tick();

        // All-ones head still fires at timer all-ones
        q = {15};
        tick(1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("t7_trig", trig_o, (k == 15));
            if (k == 15)
                chk("t7_timer_max", timer_o, 15);
        end
        chk("t7_late", err_late_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
